// File: rtl/kalman_mul_arbiter.sv
// rtl/kalman_mul_arbiter.sv - round-robin arbiter sharing one matrix multiplier across Kalman phases
// Launches the multiplier with a start pulse, then returns done or watchdog error to the granted requester.
module kalman_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int SELW    = 2,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] req_done,
  output logic [NREQ-1:0] req_err,
  output logic            mul_start,
  output logic [SELW-1:0] mul_sel,
  input  logic            mul_done,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE
  } state_t;

  localparam logic [NREQ-1:0] ONE       = NREQ'(1);
  localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT - 1);

  state_t          state;
  logic [SELW-1:0] last;
  logic [TW-1:0]   timer;
  logic [SELW-1:0] win;

  // Winner is the requester closest after the last grant, wrapping modulo NREQ.
  always_comb begin
    int best_d;
    int d;
    win    = '0;
    best_d = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - int'(last) - 1 + 2 * NREQ) % NREQ;
      if (req[i] && d < best_d) begin
        best_d = d;
        win    = SELW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt       <= '0;
      req_done  <= '0;
      req_err   <= '0;
      mul_start <= 1'b0;
      mul_sel   <= '0;
      busy      <= 1'b0;
      timer     <= '0;
      last      <= SELW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt       <= ONE << win;
            mul_sel   <= win;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          mul_start <= 1'b0;
          timer     <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the same cycle as the watchdog expiry counts as success.
          if (mul_done) begin
            req_done <= gnt;
            state    <= S_RELEASE;
          end else if (timer == TIMER_END) begin
            req_err <= gnt;
            state   <= S_RELEASE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RELEASE: begin
          req_done <= '0;
          req_err  <= '0;
          gnt      <= '0;
          last     <= mul_sel;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
